// File: rtl/soc_system_button_pkg.sv
// soc_system_button_pkg: shared defaults and per-bit debounce state type for the button conditioner
package soc_system_button_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_WIDTH = 16;
  localparam int DEF_STABLE_CYCLES = 50000;
  typedef enum logic {ST_STABLE, ST_COUNTING} state_t;
endpackage

// File: rtl/soc_system_button_debounce_if.sv
// soc_system_button_debounce_if: raw inputs in, clean levels and edge pulses out; SOC_BUTTON_EDGE_CAPTURE_EN adds edge_clear/edge_capture/irq
interface soc_system_button_debounce_if
  import soc_system_button_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] raw_in, debounced_out, rise_pulse, fall_pulse;
`ifdef SOC_BUTTON_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] edge_clear, edge_capture;
  logic irq;
  modport master(output raw_in, edge_clear, input debounced_out, rise_pulse, fall_pulse, edge_capture, irq);
  modport slave(input raw_in, edge_clear, output debounced_out, rise_pulse, fall_pulse, edge_capture, irq);
`else
  modport master(output raw_in, input debounced_out, rise_pulse, fall_pulse);
  modport slave(input raw_in, output debounced_out, rise_pulse, fall_pulse);
`endif
endinterface

// File: rtl/soc_system_debounce_bit.sv
// soc_system_debounce_bit: 2-flop sync + stability counter for one bit; ports clk, reset, raw -> deb level, rise/fall one-cycle pulses
module soc_system_debounce_bit
  import soc_system_button_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  logic sync1, sync2, done;
  logic [CNT_WIDTH-1:0] cnt;
  state_t st;
  always_comb begin
    st = (sync2 != deb) ? ST_COUNTING : ST_STABLE;
    done = (st == ST_COUNTING) && (cnt == LAST);
  end
  // counter clears on a match or on the accepting edge, so it never wraps
  always_ff @(posedge clk)
    if (reset) {sync1, sync2, cnt, deb, rise, fall} <= '0;
    else begin
      sync1 <= raw;
      sync2 <= sync1;
      cnt <= (st == ST_STABLE || done) ? '0 : cnt + CNT_WIDTH'(1);
      if (done) deb <= sync2;
      rise <= done && sync2;
      fall <= done && !sync2;
    end
endmodule

// File: rtl/soc_system_button_debounce.sv
// soc_system_button_debounce: per-bit debouncer array for PIO in_port; ports clk, reset, bus (slave); SOC_BUTTON_EDGE_CAPTURE_EN adds sticky capture + irq
module soc_system_button_debounce
  import soc_system_button_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  soc_system_button_debounce_if.slave bus
);
  logic [WIDTH-1:0] deb, rise, fall;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_system_debounce_bit #(.CNT_WIDTH(CNT_WIDTH), .STABLE_CYCLES(STABLE_CYCLES)) u_bit (
      .clk(clk), .reset(reset), .raw(bus.raw_in[i]), .deb(deb[i]), .rise(rise[i]), .fall(fall[i])
    );
  end
  assign bus.debounced_out = deb;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
`ifdef SOC_BUTTON_EDGE_CAPTURE_EN
  // set has priority over clear so a press arriving with a clear is not lost
  always_ff @(posedge clk)
    if (reset) begin
      bus.edge_capture <= '0;
      bus.irq <= 1'b0;
    end else begin
      bus.edge_capture <= rise | (bus.edge_capture & ~bus.edge_clear);
      bus.irq <= |bus.edge_capture;
    end
`endif
endmodule
